// File: rtl/alu_selftest.sv
// Self-test sequencer for the CPU ALU: sweeps LFSR operand pairs across all opcodes
// and compacts the responses into a 32-bit MISR signature checked against GOLDEN.
//
// state  | meaning
// IDLE   | waiting for start after reset
// APPLY  | operands/opcode driven, settle counter running
// SAMPLE | responses folded into the MISR, then advance opcode/pair
// DONE   | run finished, pass valid, waiting for a new start
module alu_selftest #(
    parameter int          N_VECTORS = 16,
    parameter int          OP_LAST   = 12,
    parameter int          SETTLE    = 1,
    parameter logic [31:0] SEED_X    = 32'h0000_0004,
    parameter logic [31:0] SEED_Y    = 32'h0000_0002,
    parameter logic [31:0] GOLDEN    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic [3:0]  alu_op,
    input  logic [31:0] result,
    input  logic [31:0] result2,
    input  logic        of,
    input  logic        cf,
    input  logic        equal,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] signature,
    output logic [15:0] vec_count
);

    localparam int          SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
    localparam logic [15:0] SETTLE_TC  = 16'(SETTLE_EFF - 1);
    localparam logic [15:0] VEC_LAST   = 16'(N_VECTORS - 1);
    localparam logic [3:0]  OP_MAX     = 4'(OP_LAST);
    // A zero seed would lock the operand LFSRs at zero.
    localparam logic [31:0] SX = (SEED_X == 32'h0) ? 32'h1 : SEED_X;
    localparam logic [31:0] SY = (SEED_Y == 32'h0) ? 32'h1 : SEED_Y;

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] x_nxt, y_nxt, sig_nxt, misr_val;
    logic [3:0]  op_nxt;
    logic [15:0] vec_nxt, settle_cnt, settle_nxt;
    logic        fb;

    assign fb       = signature[31] ^ signature[21] ^ signature[1] ^ signature[0];
    assign misr_val = {signature[30:0], fb} ^ result ^ {result2[15:0], result2[31:16]}
                      ^ {29'b0, of, cf, equal};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            alu_op     <= '0;
            vec_count  <= '0;
            signature  <= '0;
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            x          <= x_nxt;
            y          <= y_nxt;
            alu_op     <= op_nxt;
            vec_count  <= vec_nxt;
            signature  <= sig_nxt;
            settle_cnt <= settle_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        x_nxt      = x;
        y_nxt      = y;
        op_nxt     = alu_op;
        vec_nxt    = vec_count;
        sig_nxt    = signature;
        settle_nxt = settle_cnt;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    x_nxt      = SX;
                    y_nxt      = SY;
                    op_nxt     = '0;
                    vec_nxt    = '0;
                    sig_nxt    = '0;
                    settle_nxt = '0;
                    state_nxt  = APPLY;
                end
            end
            APPLY: begin
                if (settle_cnt == SETTLE_TC) begin
                    settle_nxt = '0;
                    state_nxt  = SAMPLE;
                end else begin
                    settle_nxt = settle_cnt + 16'd1;
                end
            end
            SAMPLE: begin
                sig_nxt = misr_val;
                if (alu_op < OP_MAX) begin
                    op_nxt    = alu_op + 4'd1;
                    state_nxt = APPLY;
                end else if (vec_count < VEC_LAST) begin
                    op_nxt    = '0;
                    vec_nxt   = vec_count + 16'd1;
                    x_nxt     = {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
                    y_nxt     = {y[30:0], y[31] ^ y[21] ^ y[1] ^ y[0]};
                    state_nxt = APPLY;
                end else begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == APPLY) || (state == SAMPLE);
    assign done = (state == DONE);
    assign pass = done && (signature == GOLDEN);

endmodule

// File: tb/tb_alu_selftest.sv
// Bench for alu_selftest: one instance on a behavioural ALU, one on tied-off responses;
// per-opcode expectations are queued at start and compared as the DUT steps through them.
module tb_alu_selftest;

    localparam logic [31:0] SEED_X = 32'h4;
    localparam logic [31:0] SEED_Y = 32'h2;
    localparam int          OP_LAST = 12;

    function automatic logic [31:0] lfsr(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    function automatic logic [31:0] alu_r(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a | b);
            4'd6:    return {31'b0, $signed(a) < $signed(b)};
            4'd7:    return {31'b0, a < b};
            4'd8:    return a << b[4:0];
            4'd9:    return a >> b[4:0];
            4'd10:   return 32'($signed(a) >>> b[4:0]);
            4'd11:   return p[31:0];
            default: return {a[15:0], b[15:0]};
        endcase
    endfunction

    function automatic logic [31:0] alu_r2(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        if (op == 4'd11) return p[63:32];
        if (op == 4'd12) return a ^ ~b;
        return 32'h0;
    endfunction

    // returns {of, cf, equal}
    function automatic logic [2:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
        logic [32:0] s;
        logic        o, c;
        o = 1'b0;
        c = 1'b0;
        if (op == 4'd0) begin
            s = {1'b0, a} + {1'b0, b};
            o = (a[31] == b[31]) && (s[31] != a[31]);
            c = s[32];
        end else if (op == 4'd1) begin
            s = {1'b0, a} - {1'b0, b};
            o = (a[31] != b[31]) && (s[31] != a[31]);
            c = s[32];
        end
        return {o, c, a == b};
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] r,
                                              input logic [31:0] r2, input logic [2:0] f);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return {s[30:0], fb} ^ r ^ {r2[15:0], r2[31:16]} ^ {29'b0, f};
    endfunction

    function automatic logic [31:0] golden_sig(input int nvec);
        logic [31:0] xv, yv, sg;
        xv = SEED_X;
        yv = SEED_Y;
        sg = 32'h0;
        for (int v = 0; v < nvec; v++) begin
            for (int op = 0; op <= OP_LAST; op++)
                sg = misr_step(sg, alu_r(xv, yv, 4'(op)), alu_r2(xv, yv, 4'(op)),
                               alu_f(xv, yv, 4'(op)));
            xv = lfsr(xv);
            yv = lfsr(yv);
        end
        return sg;
    endfunction

    localparam logic [31:0] GOLD_A = golden_sig(2);

    logic clk = 1'b0, rst = 1'b1, start_a = 1'b0, start_b = 1'b0, inject = 1'b0, sel = 1'b0;
    logic [31:0] rb_result = 32'h0;
    logic [31:0] rb_result2 = 32'h0;
    logic rb_of = 1'b0, rb_cf = 1'b0, rb_eq = 1'b0;

    logic [31:0] a_x, a_y, a_sig, ra_result, ra_result2;
    logic [3:0]  a_op;
    logic [15:0] a_vec;
    logic        a_busy, a_done, a_pass, ra_of, ra_cf, ra_eq;
    logic [31:0] b_x, b_y, b_sig;
    logic [3:0]  b_op;
    logic [15:0] b_vec;
    logic        b_busy, b_done, b_pass;

    assign ra_result  = alu_r(a_x, a_y, a_op) ^ {31'b0, inject && a_op == 4'd5 && a_vec == 16'd0};
    assign ra_result2 = alu_r2(a_x, a_y, a_op);
    assign {ra_of, ra_cf, ra_eq} = alu_f(a_x, a_y, a_op);

    alu_selftest #(.N_VECTORS(2), .OP_LAST(OP_LAST), .SETTLE(1), .SEED_X(SEED_X),
                   .SEED_Y(SEED_Y), .GOLDEN(GOLD_A)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .x(a_x), .y(a_y), .alu_op(a_op),
        .result(ra_result), .result2(ra_result2), .of(ra_of), .cf(ra_cf), .equal(ra_eq),
        .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig), .vec_count(a_vec));

    alu_selftest #(.N_VECTORS(1), .OP_LAST(OP_LAST), .SETTLE(1), .SEED_X(SEED_X),
                   .SEED_Y(SEED_Y), .GOLDEN(32'h0)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .x(b_x), .y(b_y), .alu_op(b_op),
        .result(rb_result), .result2(rb_result2), .of(rb_of), .cf(rb_cf), .equal(rb_eq),
        .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig), .vec_count(b_vec));

    always #5 clk = ~clk;

    logic [83:0] o_vec;
    logic [31:0] o_sig;
    logic [2:0]  o_stat;
    assign o_vec  = sel ? {b_x, b_y, b_op, b_vec} : {a_x, a_y, a_op, a_vec};
    assign o_sig  = sel ? b_sig : a_sig;
    assign o_stat = sel ? {b_busy, b_done, b_pass} : {a_busy, a_done, a_pass};

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [83:0] vec;
        logic [31:0] sig;
    } rec_t;
    rec_t sb[$];

    // s=1 selects u_b; poke pulses start mid-run, which must have no effect
    task automatic run(input logic s, input int nvec, input bit inj, input bit poke);
        logic [31:0] xv, yv, sg, r, r2, gold;
        logic [2:0]  f;
        rec_t        rc;
        int          k;
        sb.delete();
        sel    = s;
        inject = inj;
        gold   = s ? 32'h0 : GOLD_A;
        xv = SEED_X;
        yv = SEED_Y;
        sg = 32'h0;
        for (int v = 0; v < nvec; v++) begin
            for (int op = 0; op <= OP_LAST; op++) begin
                if (s) begin
                    r  = rb_result;
                    r2 = 32'h0;
                    f  = 3'b0;
                end else begin
                    r  = alu_r(xv, yv, 4'(op)) ^ {31'b0, inj && op == 5 && v == 0};
                    r2 = alu_r2(xv, yv, 4'(op));
                    f  = alu_f(xv, yv, 4'(op));
                end
                sg     = misr_step(sg, r, r2, f);
                rc.vec = {xv, yv, 4'(op), 16'(v)};
                rc.sig = sg;
                sb.push_back(rc);
            end
            xv = lfsr(xv);
            yv = lfsr(yv);
        end
        @(negedge clk);
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        k = 0;
        while (sb.size() > 0) begin
            rc = sb.pop_front();
            if (poke && k == 3) begin
                if (s) start_b = 1'b1; else start_a = 1'b1;
            end
            check("apply", {o_vec, o_stat}, {rc.vec, 3'b100});
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            check("sample", {o_vec, o_stat}, {rc.vec, 3'b100});
            @(negedge clk);
            check("sig", o_sig, rc.sig);
            k++;
        end
        check("done", o_stat, {2'b01, sg == gold});
    endtask

    initial begin
        #2;
        check("rst_a", {a_x, a_y, a_op, a_busy, a_done, a_pass, a_sig, a_vec}, '0);
        check("rst_b", {b_x, b_y, b_op, b_busy, b_done, b_pass, b_sig, b_vec}, '0);
        @(negedge clk);
        rst = 1'b0;

        rb_result = 32'h0;
        run(1'b1, 1, 1'b0, 1'b0);
        rb_result = 32'h1;
        run(1'b1, 1, 1'b0, 1'b1);

        run(1'b0, 2, 1'b0, 1'b0);
        run(1'b0, 2, 1'b1, 1'b0);

        sel    = 1'b0;
        inject = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_a", {a_x, a_y, a_op, a_busy, a_done, a_pass, a_sig, a_vec}, '0);
        check("rst_mid_b", {b_x, b_y, b_op, b_busy, b_done, b_pass, b_sig, b_vec}, '0);
        @(negedge clk);
        rst = 1'b0;
        run(1'b0, 2, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_selftest.md
# alu_selftest

Synthesizable self-test sequencer for the single-cycle CPU's ALU. It drives operand pairs and every ALU opcode into the `alu` block and collects the responses: `result`, `result2`, `of`, `cf` and `equal`. The responses are compacted into a 32-bit MISR signature, which is compared against a golden value. It sits beside `alu` and shares its operand and opcode inputs through a test-mode mux that lives outside this block.

## Interface
Parameters:
- `N_VECTORS`, default 16: number of operand pairs, ≥1.
- `OP_LAST`, default 12: highest `alu_op` applied. Opcodes 0..`OP_LAST` are swept per pair.
- `SETTLE`, default 1: hold cycles before sampling. 0 is treated as 1.
- `SEED_X`, default 32'h00000004: first `x`. A zero value is replaced by 1.
- `SEED_Y`, default 32'h00000002: first `y`. A zero value is replaced by 1.
- `GOLDEN`, default 32'h00000000: expected final signature.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a run. Sampled in IDLE or DONE only.
- `x` out 32: operand to the ALU.
- `y` out 32: operand to the ALU.
- `alu_op` out 4: opcode to the ALU.
- `result` in 32: ALU response.
- `result2` in 32: ALU response.
- `of` in 1: ALU flag.
- `cf` in 1: ALU flag.
- `equal` in 1: ALU flag.
- `busy` out 1: high while a run is in progress.
- `done` out 1: level, high in DONE.
- `pass` out 1: valid when `done`=1. Signature equals `GOLDEN`.
- `signature` out 32: live MISR value.
- `vec_count` out 16: index of the current operand pair.

## Operation
- States: IDLE, APPLY, SAMPLE, DONE. Reset enters IDLE.
- IDLE/DONE with `start`=1 does the following, then goes to APPLY:
  - `x`←`SEED_X`, `y`←`SEED_Y`, `alu_op`←0, `vec_count`←0.
  - signature←0, `pass`←0, `done`←0, settle counter←0.
- APPLY: outputs are held and the settle counter increments. After `SETTLE` cycles, go to SAMPLE.
- SAMPLE: outputs are still held. At the end of the cycle, the signature updates:
  - fb = sig[31]^sig[21]^sig[1]^sig[0].
  - sig ← {sig[30:0],fb} ^ `result` ^ {`result2`[15:0],`result2`[31:16]} ^ {29'b0,`of`,`cf`,`equal`}.
- After a SAMPLE update, exactly one of these applies:
  - `alu_op` < `OP_LAST`: `alu_op`+1, go to APPLY.
  - `alu_op` = `OP_LAST` and `vec_count` < `N_VECTORS`-1: `alu_op`←0 and `vec_count`+1.
    - `x` advances as {x[30:0], x[31]^x[21]^x[1]^x[0]}, and `y` the same way.
    - Go to APPLY.
  - Otherwise, go to DONE.
- DONE: `done`=1, `busy`=0, `pass`=(signature==`GOLDEN`). Outputs hold until `start` or `rst`.
- `start` while `busy`=1 is ignored.
- The LFSR taps are maximal-length and seeds are forced non-zero, so operands never reach 0.

## Timing
- Reset values of all outputs:
  - `x`=0, `y`=0, `alu_op`=0.
  - `busy`=0, `done`=0, `pass`=0.
  - `signature`=0, `vec_count`=0.
- Reset is asynchronous. Asserting `rst` mid-run returns the block to IDLE immediately, and a later `start` begins a fresh run.
- `start` sampled at edge E0 ⇒ `busy`=1 and the first vector is driven after E0.
- Each opcode occupies `SETTLE`+1 cycles. The ALU inputs are stable for that whole window, and the sample is taken at the last edge.
- `done` rises at edge E0 + `N_VECTORS`·(`OP_LAST`+1)·(`SETTLE`+1). `busy` falls at the same edge.
- Defaults: 16·13·2 = 416 cycles.
- The ALU is purely combinational, so `SETTLE`=1 is sufficient.

## Test plan
- **Sweep:** `N_VECTORS`=1, `SETTLE`=1, pulse `start`.
  - `x`=0x4, `y`=0x2 throughout.
  - `alu_op` steps 0..12, with each value held 2 cycles.
  - `done` rises 26 cycles after the start edge.
- **Operand advance:** `N_VECTORS`=2. The second pair is `x`=0x8, `y`=0x5, and `vec_count`=1 during it.
- **MISR:** tie all responses to 0 ⇒ signature stays 0, and `pass`=1 with `GOLDEN`=0.
  - Then tie `result`=1 with other responses 0: signature =0x1 after the 1st sample and 0x2 after the 2nd.
  - Use `GOLDEN`≠computed ⇒ `pass`=0.
- **Real ALU:** compare `signature` against an off-line model run over the same vectors, with `GOLDEN` set from that model ⇒ `pass`=1.
  - Flip one `result` bit on one opcode ⇒ `pass`=0.
- **`start` during `busy`:** no effect; timing is unchanged.
  - `start` in DONE restarts the run, clears `done`/`pass`, and reloads the seeds.
- **`rst` mid-run** (cycle 7): all outputs return to their reset values asynchronously. A following `start` completes normally with the same signature as an uninterrupted run.
